// File: rtl/uart_rx_block_collector.sv
// UART receiver that packs N_BYTES frames into one block and offers it on a double-buffered
// valid/ready output. Optional feature macro: UART_RX_TIMEOUT_EN (discard stale partial blocks).
module uart_rx_block_collector #(
   parameter int N_DATA_BITS   = 8,
   parameter int N_BYTES       = 16,
   parameter int OVERSAMPLE    = 16,
   parameter int TIMEOUT_TICKS = 4096
) (
   input  logic                           i_uart_clk,
   input  logic                           i_uart_reset,
   input  logic                           i_uart_en,
   input  logic                           i_uart_rx,
   input  logic                           i_block_ready,
   output logic [N_DATA_BITS*N_BYTES-1:0] o_block,
   output logic                           o_block_valid,
   output logic [$clog2(N_BYTES):0]       o_byte_count,
   output logic                           o_frame_err,
   output logic                           o_overrun,
   output logic                           o_timeout
);

   localparam int BLK_W = N_DATA_BITS * N_BYTES;
   localparam int BC_W  = $clog2(N_BYTES) + 1;
   localparam int TK_W  = $clog2(OVERSAMPLE);
   localparam int BT_W  = $clog2(N_DATA_BITS) + 1;

   localparam logic [TK_W-1:0] TICK_MID  = TK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TK_W-1:0] TICK_LAST = TK_W'(OVERSAMPLE - 1);
   localparam logic [BT_W-1:0] BIT_LAST  = BT_W'(N_DATA_BITS - 1);
   localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(N_BYTES - 1);

   if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
      $error("OVERSAMPLE must be even and at least 4");
   end
   if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
      $error("TIMEOUT_TICKS must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                 state_q;
   logic [TK_W-1:0]        tick_q;
   logic [BT_W-1:0]        bit_q;
   logic [N_DATA_BITS-1:0] shift_q;
   logic                   rx_meta_q;
   logic                   rx_sync_q;
   logic                   frame_err_q;

   logic [BLK_W-1:0]       assembly_q;
   logic [BLK_W-1:0]       assembly_d;
   logic [BC_W-1:0]        byte_count_q;
   logic [BLK_W-1:0]       block_q;
   logic                   valid_q;
   logic                   overrun_q;

   logic                   byte_good;
   logic                   block_done;
   logic                   timeout_hit;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge i_uart_clk or posedge i_uart_reset) begin
      if (i_uart_reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         rx_meta_q <= i_uart_rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   always_ff @(posedge i_uart_clk or posedge i_uart_reset) begin
      if (i_uart_reset) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (i_uart_en) begin
            case (state_q)
               S_IDLE: begin
                  if (!rx_sync_q) begin
                     state_q <= S_START;
                     tick_q  <= '0;
                  end
               end
               S_START: begin
                  if (tick_q == TICK_MID) begin
                     tick_q  <= '0;
                     bit_q   <= '0;
                     state_q <= rx_sync_q ? S_IDLE : S_DATA;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               S_DATA: begin
                  if (tick_q == TICK_LAST) begin
                     tick_q  <= '0;
                     shift_q <= {rx_sync_q, shift_q[N_DATA_BITS-1:1]};
                     bit_q   <= bit_q + 1'b1;
                     if (bit_q == BIT_LAST) state_q <= S_STOP;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               S_STOP: begin
                  if (tick_q == TICK_LAST) begin
                     tick_q <= '0;
                     if (rx_sync_q) begin
                        state_q <= S_IDLE;
                     end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_BREAK;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               S_BREAK: begin
                  if (rx_sync_q) state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign byte_good  = i_uart_en && (state_q == S_STOP) && (tick_q == TICK_LAST) && rx_sync_q;
   assign block_done = byte_good && (byte_count_q == BYTE_LAST);

   always_comb begin
      // NOTE: default first so every path assigns assembly_d; otherwise a latch is inferred.
      assembly_d = assembly_q;
      for (int i = 0; i < N_BYTES; i++) begin
         if (byte_count_q == BC_W'(i)) assembly_d[i*N_DATA_BITS +: N_DATA_BITS] = shift_q;
      end
   end

   always_ff @(posedge i_uart_clk or posedge i_uart_reset) begin
      if (i_uart_reset) begin
         // NOTE: the assembly buffer is reset too; it is small enough that clearing it costs
         // nothing and keeps a post-reset o_block deterministic.
         assembly_q   <= '0;
         byte_count_q <= '0;
         block_q      <= '0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (byte_good) begin
            assembly_q   <= assembly_d;
            byte_count_q <= block_done ? '0 : byte_count_q + 1'b1;
         end else if (timeout_hit) begin
            byte_count_q <= '0;
         end

         // A slot freed on this same edge can take the new block immediately.
         if (block_done && (!valid_q || i_block_ready)) begin
            block_q <= assembly_d;
            valid_q <= 1'b1;
         end else begin
            if (block_done) overrun_q <= 1'b1;
            if (valid_q && i_block_ready) valid_q <= 1'b0;
         end
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   localparam int ID_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [ID_W-1:0] IDLE_LAST = ID_W'(TIMEOUT_TICKS - 1);

   logic [ID_W-1:0] idle_q;
   logic            timeout_q;

   assign timeout_hit = i_uart_en && (state_q == S_IDLE) && rx_sync_q &&
                        (byte_count_q != '0) && (idle_q == IDLE_LAST);

   always_ff @(posedge i_uart_clk or posedge i_uart_reset) begin
      if (i_uart_reset) begin
         idle_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_hit;
         if ((byte_count_q == '0) || timeout_hit ||
             (i_uart_en && (state_q == S_IDLE) && !rx_sync_q)) begin
            idle_q <= '0;
         end else if (i_uart_en && (state_q == S_IDLE)) begin
            idle_q <= idle_q + 1'b1;
         end
      end
   end

   assign o_timeout = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign o_timeout   = 1'b0;
`endif

   assign o_block       = block_q;
   assign o_block_valid = valid_q;
   assign o_byte_count  = byte_count_q;
   assign o_frame_err   = frame_err_q;
   assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_block_collector.sv
// Self-checking bench for uart_rx_block_collector: byte-level model checked every cycle,
// plus literal expectations for the block contents, byte counts and pulse counts.
module tb_uart_rx_block_collector;

   localparam int NB = 16;
   localparam int TO = 4096;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         en    = 1'b0;
   logic         rx    = 1'b1;
   logic         ready = 1'b0;
   logic [127:0] blk;
   logic         valid;
   logic [4:0]   cnt;
   logic         ferr;
   logic         ovr;
   logic         tmo;

   // Byte-level model of the receiver outputs.
   logic [127:0] exp_asm   = '0;
   logic [127:0] exp_block = '0;
   int           exp_count = 0;
   logic         exp_valid = 1'b0;
   logic         exp_ferr  = 1'b0;
   logic         exp_ovr   = 1'b0;
   logic         exp_tmo   = 1'b0;

   int n_checks    = 0;
   int n_errors    = 0;
   int n_ferr_seen = 0;
   int n_ovr_seen  = 0;
   int n_tmo_seen  = 0;

   uart_rx_block_collector #(
      .N_DATA_BITS  (8),
      .N_BYTES      (NB),
      .OVERSAMPLE   (16),
      .TIMEOUT_TICKS(TO)
   ) dut (
      .i_uart_clk   (clk),
      .i_uart_reset (rst),
      .i_uart_en    (en),
      .i_uart_rx    (rx),
      .i_block_ready(ready),
      .o_block      (blk),
      .o_block_valid(valid),
      .o_byte_count (cnt),
      .o_frame_err  (ferr),
      .o_overrun    (ovr),
      .o_timeout    (tmo)
   );

   always #5 clk = ~clk;
   always @(negedge clk) en = ~en;   // tick on every second rising edge

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   endtask

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
         if (n_errors >= 40) finish_run();
      end
   endtask

   task automatic model_reset();
      exp_asm   = '0;
      exp_block = '0;
      exp_count = 0;
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      exp_ovr   = 1'b0;
      exp_tmo   = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic rdy);
      exp_asm[exp_count*8 +: 8] = b;
      exp_count++;
      if (exp_count == NB) begin
         exp_count = 0;
         if (!exp_valid || rdy) begin
            exp_block = exp_asm;
            exp_valid = 1'b1;
         end else begin
            exp_ovr = 1'b1;
         end
      end
   endtask

   // Outputs compared against the model on every falling edge.
   always @(negedge clk) begin
      check("outputs", {valid, cnt, ferr, ovr, tmo, blk},
            {exp_valid, 5'(exp_count), exp_ferr, exp_ovr, exp_tmo, exp_block});
      if (ferr) n_ferr_seen++;
      if (ovr)  n_ovr_seen++;
      if (tmo)  n_tmo_seen++;
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      exp_tmo  = 1'b0;
   end

   task automatic wait_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         while (!en) @(posedge clk);
      end
   endtask

   // Starts right after a tick edge; returns on the tick edge that ends the frame.
   // The stop sample falls on the 10th tick of the stop bit (2-clock synchroniser + mid-bit).
   task automatic tx_byte(input logic [7:0] b, input int stop_low, input logic rdy);
      #1 rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         #1 rx = b[i];
         wait_ticks(16);
      end
      #1 rx = (stop_low == 0);
      wait_ticks(9);
      @(negedge clk);
      @(negedge clk);
      ready = rdy;
      wait_ticks(1);
      if (stop_low == 0) model_byte(b, rdy);
      else               exp_ferr = 1'b1;
      #1 ready = 1'b0;
      if (stop_low == 0) begin
         wait_ticks(6);
      end else begin
         wait_ticks(16 * stop_low - 10);
         #1 rx = 1'b1;
         wait_ticks(16);
      end
   endtask

   task automatic pulse_ready();
      @(negedge clk);
      ready = 1'b1;
      @(posedge clk);
      exp_valid = 1'b0;
      #1 ready = 1'b0;
      wait_ticks(1);
   endtask

   initial begin
      #1_500_000;
      n_errors++;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #2 check("reset outputs", {valid, cnt, ferr, ovr, tmo, blk}, '0);
      wait_ticks(2);

      // Basic block, ready low.
      for (int i = 0; i < 16; i++) tx_byte(8'(i), 0, 1'b0);
      #2;
      check("basic block", blk, 128'h0F0E0D0C0B0A09080706050403020100);
      check("basic valid", valid, 1);
      check("basic count", cnt, 0);
      pulse_ready();
      check("accept clears valid", valid, 0);

      // Overrun: block A held, block B dropped.
      for (int i = 0; i < 16; i++) tx_byte(8'(i), 0, 1'b0);
      for (int i = 0; i < 16; i++) tx_byte(8'h10 + 8'(i), 0, 1'b0);
      #2;
      check("overrun pulses", n_ovr_seen, 1);
      check("overrun keeps A", blk, 128'h0F0E0D0C0B0A09080706050403020100);
      check("overrun valid", valid, 1);

      // Accept on the completion edge.
      for (int i = 0; i < 16; i++) tx_byte(8'h30 + 8'(i), 0, i == 15);
      #2;
      check("same-edge no overrun", n_ovr_seen, 1);
      check("same-edge block", blk, 128'h3F3E3D3C3B3A39383736353433323130);
      check("same-edge valid", valid, 1);
      pulse_ready();

      // Frame error on the fifth byte, then a glitch, then the rest of the block.
      for (int i = 0; i < 4; i++) tx_byte(8'h40 + 8'(i), 0, 1'b0);
      tx_byte(8'h44, 3, 1'b0);
      #2;
      check("frame err pulses", n_ferr_seen, 1);
      check("count held over error", cnt, 4);
      #1 rx = 1'b0;
      wait_ticks(4);
      #1 rx = 1'b1;
      wait_ticks(20);
      #2;
      check("count after glitch", cnt, 4);
      check("glitch no pulses", n_ferr_seen + n_ovr_seen + n_tmo_seen, 2);
      for (int i = 5; i < 17; i++) tx_byte(8'h40 + 8'(i), 0, 1'b0);
      #2;
      check("frame err block", blk, 128'h504F4E4D4C4B4A494847464543424140);
      check("frame err valid", valid, 1);

      // Partial block left idle (block above stays held).
      for (int i = 0; i < 3; i++) tx_byte(8'h60 + 8'(i), 0, 1'b0);
      #2 check("partial count", cnt, 3);
      wait_ticks(TO - 6);
`ifdef UART_RX_TIMEOUT_EN
      exp_count = 0;
      exp_tmo   = 1'b1;
`endif
      wait_ticks(10);
      #2;
`ifdef UART_RX_TIMEOUT_EN
      check("timeout count", cnt, 0);
      check("timeout pulses", n_tmo_seen, 1);
`else
      check("no timeout count", cnt, 3);
      check("no timeout pulses", n_tmo_seen, 0);
`endif
      check("held block survives idle", blk, 128'h504F4E4D4C4B4A494847464543424140);

      // Reset in the middle of the seventh byte.
      for (int i = 0; i < 6; i++) tx_byte(8'h20 + 8'(i), 0, 1'b0);
      #1 rx = 1'b0;
      wait_ticks(16);
      #1 rx = 1'b1;
      wait_ticks(40);
      #1 rst = 1'b1;
      model_reset();
      #2 check("mid-byte reset outputs", {valid, cnt, ferr, ovr, tmo, blk}, '0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      wait_ticks(2);
      for (int i = 0; i < 16; i++) tx_byte(8'h70 + 8'(i), 0, 1'b0);
      #2;
      check("post-reset block", blk, 128'h7F7E7D7C7B7A79787776757473727170);
      check("post-reset valid", valid, 1);
      check("post-reset count", cnt, 0);

      wait_ticks(4);
      finish_run();
   end

endmodule

// File: doc/uart_rx_block_collector.md
# uart_rx_block_collector

Receive side of the AES/UART link. The block deserialises the UART line, assembles N_BYTES bytes into one N_DATA_BITS*N_BYTES-bit block, and presents that block to the AES core over a valid/ready handshake. Byte 0 lands in bits [7:0], which matches the transmit controller's order of chunk 0 first. The block is double-buffered: reception of the next block continues while the previous block waits for acceptance.

## Interface
- N_DATA_BITS, 8, data bits per UART frame
- N_BYTES, 16, bytes per block
- OVERSAMPLE, 16, i_uart_en ticks per bit period (even, ≥4)
- TIMEOUT_TICKS, 4096, idle ticks before a partial block is discarded
- i_uart_clk  in  1  system clock
- i_uart_reset  in  1  reset, asynchronous, active-high
- i_uart_en  in  1  one-clock oversample strobe at OVERSAMPLE×baud
- i_uart_rx  in  1  serial line, asynchronous, idle high; LSB first, 1 start bit, 1 stop bit, no parity
- i_block_ready  in  1  downstream accepts o_block
- o_block  out  N_DATA_BITS*N_BYTES  assembled block
- o_block_valid  out  1  o_block holds an unaccepted block
- o_byte_count  out  $clog2(N_BYTES)+1  bytes in the current partial block
- o_frame_err  out  1  one-cycle pulse when a stop bit is bad
- o_overrun  out  1  one-cycle pulse when a completed block is dropped
- o_timeout  out  1  one-cycle pulse when a partial block is discarded

## Operation
- **Synchroniser:** i_uart_rx passes through a 2-flop synchroniser, which resets to 1. All FSM sampling uses the synchronised value, and the FSM advances only on cycles with i_uart_en=1.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. A tick counter runs from 0 to OVERSAMPLE-1.
  - IDLE: when rx=0 on a tick → START, counter=0.
  - START: at counter=OVERSAMPLE/2-1, if rx=0 → DATA with counter cleared; if rx=1 → IDLE (glitch, nothing recorded).
  - DATA: at counter=OVERSAMPLE-1, shift rx in LSB-first. After N_DATA_BITS bits → STOP.
  - STOP: at counter=OVERSAMPLE-1, if rx=1 → byte good, → IDLE. If rx=0 → pulse o_frame_err, discard the byte, → BREAK.
  - BREAK: when rx=1 on a tick → IDLE.
- **Assembly:** a good byte is written to assembly[o_byte_count*N_DATA_BITS +: N_DATA_BITS], then o_byte_count increments. A discarded byte leaves o_byte_count unchanged.
- **Block completion:** when the N_BYTES-th good byte arrives, o_byte_count wraps to 0. The completed block is then handled as follows:
  - Output slot free (o_block_valid=0) or freed this cycle (o_block_valid & i_block_ready): copy the block to o_block and set o_block_valid=1.
  - Otherwise: drop the block, pulse o_overrun, and leave o_block unchanged.
- **Handshake:** a block is accepted on any edge where o_block_valid & i_block_ready. o_block_valid then clears, unless a completion occurs on the same edge, in which case it stays 1 with the new data. o_block is stable while o_block_valid=1.

## Timing
- **Reset values:** o_block=0, o_block_valid=0, o_byte_count=0, all pulses 0. FSM=IDLE, synchroniser=1, counters=0.
- **Reset mid-frame or mid-block:** the partial byte and partial block are lost, and a held o_block is cleared.
- **Start detection latency:** 2 clocks of synchroniser, plus up to 1 tick.
- **Byte completion:** the stop sample occurs on a tick cycle T. o_byte_count, the assembly register, o_block, o_block_valid, o_frame_err and o_overrun all update on the edge ending cycle T, so they are visible in T+1. The pulses last exactly one clock.
- **Back-to-back frames:** a start bit immediately after the stop bit is received with no lost byte.

## Configuration
- **UART_RX_TIMEOUT_EN defined:**
  - An idle counter increments on ticks while FSM=IDLE and o_byte_count≠0.
  - It clears on entry to START and whenever o_byte_count=0.
  - On reaching TIMEOUT_TICKS: o_byte_count←0, o_timeout pulses for 1 clock, the counter clears. A held o_block is unaffected.
- **Undefined:** the counter logic is absent, o_timeout is tied 0, and a partial block persists indefinitely.

## Test plan
- **Basic block:** OVERSAMPLE=16, send bytes 0x00..0x0F with i_block_ready=0 → o_block=128'h0F0E0D0C0B0A09080706050403020100, o_block_valid=1, o_byte_count=0. Raise ready for 1 clock → valid=0.
- **Overrun:** keep ready=0, send block A (0x00..0x0F) then block B (0x10..0x1F) → o_overrun pulses once at B's 16th stop sample, o_block still equals A.
- **Accept on completion edge:** with A held, assert ready on the exact edge where B's 16th byte completes → no o_overrun, o_block=B, valid stays 1.
- **Frame error:** drive the stop bit of byte 5 low for 3 bit periods, then idle and continue the block → o_frame_err pulses once, byte 5 is not stored. The next good byte goes to index 4 and o_byte_count=4 is held across the error.
- **Glitch:** pulse rx low for 4 ticks → no state change, o_byte_count unchanged, no pulses.
- **Timeout and reset:**
  - With UART_RX_TIMEOUT_EN: send 3 bytes, then idle TIMEOUT_TICKS+1 ticks → o_timeout pulses, o_byte_count=0. Without the macro → o_byte_count stays 3.
  - Assert i_uart_reset mid-byte 7 → all outputs 0, and the next 16 bytes form a clean block.
